// File: rtl/fu_mul_pipe_pkg.sv
// Shared definitions for the pipelined multiply functional unit.
// The op encodings match the ones the decoder and reservation stations use,
// so an op field can be passed straight from the RS entry to this unit.
package fu_mul_pipe_pkg;

    localparam int MUL_OP_W = 2;

    typedef enum logic [MUL_OP_W-1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    // rs1 is treated as signed for every op except MULHU.
    function automatic logic op_a_signed(mul_op_e o);
        return o != MUL_OP_MULHU;
    endfunction

    // rs2 is treated as signed only for MUL and MULH.
    function automatic logic op_b_signed(mul_op_e o);
        return (o == MUL_OP_MUL) || (o == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/fu_mul_pipe_core.sv
// mul_pipe_core: signed (W+1)x(W+1) multiplier spread over LATENCY register
// stages, all sharing one enable so the whole datapath freezes together.
// Only the low 2W product bits are produced; they are exact for every op
// because the upper result half never needs bits above 2W-1.
//   clk, rst_n : clock, async active-low reset (clears all data regs)
//   en         : advance every stage this cycle
//   a, b       : already-extended signed operands (W+1 bits)
//   p          : product, low 2W bits, from the last stage
module mul_pipe_core #(
    parameter int W       = 32,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [W:0]     a,
    input  logic [W:0]     b,
    output logic [2*W-1:0] p
);

    localparam int PW = 2 * W;
    localparam int H  = W / 2;
    localparam int HW = W - H + 1;   // width of the signed upper slice of b

    function automatic logic [PW-1:0] sext_op(logic [W:0] x);
        return {{(PW-W-1){x[W]}}, x};
    endfunction

    if (LATENCY == 1) begin : g_lat1
        logic [PW-1:0] p_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  p_q <= '0;
            else if (en) p_q <= sext_op(a) * sext_op(b);
        end

        assign p = p_q;
    end else begin : g_latn
        logic [W:0] a_q, b_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
            end else if (en) begin
                a_q <= a;
                b_q <= b;
            end
        end

        if (LATENCY == 2) begin : g_lat2
            logic [PW-1:0] p_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  p_q <= '0;
                else if (en) p_q <= sext_op(a_q) * sext_op(b_q);
            end

            assign p = p_q;
        end else begin : g_lat3p
            // b = b_hi * 2^H + b_lo, with b_lo unsigned and b_hi carrying the sign.
            logic [PW-1:0] b_lo_x, b_hi_x;
            logic [PW-1:0] pp_lo_q, pp_hi_q;
            logic [PW-1:0] stg_q [LATENCY-2];

            assign b_lo_x = {{(PW-H){1'b0}}, b_q[H-1:0]};
            assign b_hi_x = {{(PW-HW){b_q[W]}}, b_q[W:H]};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pp_lo_q <= '0;
                    pp_hi_q <= '0;
                    for (int i = 0; i < LATENCY - 2; i++) stg_q[i] <= '0;
                end else if (en) begin
                    pp_lo_q  <= sext_op(a_q) * b_lo_x;
                    pp_hi_q  <= sext_op(a_q) * b_hi_x;
                    stg_q[0] <= pp_lo_q + (pp_hi_q << H);
                    for (int i = 1; i < LATENCY - 2; i++) stg_q[i] <= stg_q[i-1];
                end
            end

            assign p = stg_q[LATENCY-3];
        end
    end

endmodule

// File: rtl/fu_mul_pipe.sv
// fu_mul_pipe: fully pipelined integer multiply FU (MUL/MULH/MULHSU/MULHU),
// one op per cycle, LATENCY cycles with no stall, tag carried with each op.
//   clk, rst_n          : clock, async active-low reset
//   flush               : kill every in-flight op (incl. same-cycle request)
//   in_valid/in_ready   : request handshake; op, a, b, tag are the request
//   out_valid/out_ready : result handshake; res, out_tag are the result
// The pipe has no bubble collapsing: any stall at the output freezes every
// stage, so in_ready is simply the inverse of the output stall.
module fu_mul_pipe
    import fu_mul_pipe_pkg::*;
#(
    parameter int W       = 32,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     res,
    output logic [TAG_W-1:0] out_tag
);

    logic [LATENCY-1:0] vld_q;
    mul_op_e            op_q  [LATENCY];
    logic [TAG_W-1:0]   tag_q [LATENCY];

    logic               stall, en;
    mul_op_e            op_in;
    logic [W:0]         a_ext, b_ext;
    logic [2*W-1:0]     prod;

    assign stall    = vld_q[LATENCY-1] & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    assign op_in = mul_op_e'(op);
    assign a_ext = {op_a_signed(op_in) & a[W-1], a};
    assign b_ext = {op_b_signed(op_in) & b[W-1], b};

    // Flush only clears the valid bits; the data regs keep moving with en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                op_q[i]  <= MUL_OP_MUL;
                tag_q[i] <= '0;
            end
        end else if (en) begin
            op_q[0]  <= op_in;
            tag_q[0] <= tag;
            for (int i = 1; i < LATENCY; i++) begin
                op_q[i]  <= op_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    mul_pipe_core #(
        .W       (W),
        .LATENCY (LATENCY)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a_ext),
        .b     (b_ext),
        .p     (prod)
    );

    assign out_valid = vld_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign res       = (op_q[LATENCY-1] == MUL_OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];

endmodule
